// File: rtl/av_selector_pipe_if.sv
// ---------------------------------------------------------------------------
// av_selector_pipe_if
//   Signal bundle for the registered channel selector.
//   master : the data source / controller side (drives din, sel, strobes)
//   slave  : the selector itself (drives dout, dout_valid, sel_active, pending)
//
//   ce          pixel clock enable
//   din         CHANNELS packed words, channel k at din[k*WIDTH +: WIDTH]
//   din_valid   qualifies din in the current ce cycle
//   sel         requested channel
//   sel_load    capture sel into the pending select register
//   sel_apply   promote the pending select to active (only when ce=1)
//   inv         runtime output inversion toggle
//   dout        selected, possibly inverted, word
//   dout_valid  qualifier for dout
//   sel_active  select currently steering the pipeline
//   pending     a loaded select is waiting for an apply strobe
// ---------------------------------------------------------------------------
interface av_selector_pipe_if #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2
);
    logic                      ce;
    logic [CHANNELS*WIDTH-1:0] din;
    logic                      din_valid;
    logic [SEL_W-1:0]          sel;
    logic                      sel_load;
    logic                      sel_apply;
    logic                      inv;
    logic [WIDTH-1:0]          dout;
    logic                      dout_valid;
    logic [SEL_W-1:0]          sel_active;
    logic                      pending;

    modport master (
        output ce, din, din_valid, sel, sel_load, sel_apply, inv,
        input  dout, dout_valid, sel_active, pending
    );

    modport slave (
        input  ce, din, din_valid, sel, sel_load, sel_apply, inv,
        output dout, dout_valid, sel_active, pending
    );
endinterface

// File: rtl/av_selector_pipe.sv
// ---------------------------------------------------------------------------
// av_selector_pipe
//   Registered, parametrised N:1 word selector with optional inversion.
//   The select is double-buffered: sel_load fills a pending register at any
//   time, and sel_apply (on a ce cycle) makes it active, so a switch only
//   takes effect at a boundary chosen by the controller. Data passes through
//   two ce-gated register stages (select/capture, then inversion).
//
//   Ports:
//     clk     system clock
//     nRESET  asynchronous active-low reset
//     bus     av_selector_pipe_if slave modport (see interface header)
// ---------------------------------------------------------------------------
module av_selector_pipe #(
    parameter int               WIDTH    = 4,
    parameter int               CHANNELS = 4,
    parameter int               SEL_W    = 2,
    parameter bit               INVERT   = 1'b1,
    parameter logic [WIDTH-1:0] FILL     = '0
) (
    input  logic                 clk,
    input  logic                 nRESET,
    av_selector_pipe_if.slave    bus
);

    logic [SEL_W-1:0] pend_sel_reg;
    logic [SEL_W-1:0] sel_active_reg;
    logic             pending_reg;

    logic [WIDTH-1:0] s1_data_reg;
    logic             s1_inv_reg;
    logic             s1_v_reg;
    logic [WIDTH-1:0] dout_reg;
    logic             dout_valid_reg;

    logic [WIDTH-1:0] chan_word [CHANNELS];
    logic [WIDTH-1:0] mux_word;

    // Unpack the flat input bus into per-channel words.
    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_unpack
            assign chan_word[gi] = bus.din[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Codes with no channel behind them (select >= CHANNELS) fall through to FILL.
    always_comb begin
        mux_word = FILL;
        for (int k = 0; k < CHANNELS; k++) begin
            if (int'(sel_active_reg) == k) begin
                mux_word = chan_word[k];
            end
        end
    end

    // Select double-buffer. sel_load is not ce-gated; sel_apply is.
    // A load coinciding with an apply bypasses the pending register so the
    // newest request wins.
    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            pend_sel_reg   <= '0;
            sel_active_reg <= '0;
            pending_reg    <= 1'b0;
        end else begin
            if (bus.sel_load) begin
                pend_sel_reg <= bus.sel;
            end
            if (bus.ce && bus.sel_apply && bus.sel_load) begin
                sel_active_reg <= bus.sel;
                pending_reg    <= 1'b0;
            end else if (bus.ce && bus.sel_apply && pending_reg) begin
                sel_active_reg <= pend_sel_reg;
                pending_reg    <= 1'b0;
            end else if (bus.sel_load) begin
                pending_reg    <= 1'b1;
            end
        end
    end

    // Two-stage pipeline. Stage 1 sees sel_active_reg before any same-cycle
    // apply, so a new select steers the following ce sample.
    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            s1_data_reg    <= '0;
            s1_inv_reg     <= 1'b0;
            s1_v_reg       <= 1'b0;
            dout_reg       <= '0;
            dout_valid_reg <= 1'b0;
        end else if (bus.ce) begin
            s1_data_reg    <= mux_word;
            s1_inv_reg     <= bus.inv ^ INVERT;
            s1_v_reg       <= bus.din_valid;
            dout_reg       <= s1_inv_reg ? ~s1_data_reg : s1_data_reg;
            dout_valid_reg <= s1_v_reg;
        end
    end

    assign bus.dout       = dout_reg;
    assign bus.dout_valid = dout_valid_reg;
    assign bus.sel_active = sel_active_reg;
    assign bus.pending    = pending_reg;

endmodule
